// File: rtl/oric_pkg.sv
// rtl/oric_pkg.sv - shared RAM widths and controller state encoding
//
// Package contents:
//   ADDR_W  - RAM address width (16)
//   DATA_W  - RAM data width (8)
//   state_t - controller states: clear, CPU run, loader write, loader flush

package oric_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/oric_ram_ctrl.sv
// rtl/oric_ram_ctrl.sv - single-port RAM arbiter: power-on clear, CPU access, loader download
//
// Ports:
//   clk_sys, RESET                    clock, synchronous active-high reset
//   cpu_ad/cpu_d/cpu_cs/cpu_we        CPU RAM request
//   cpu_q                             CPU read data (RAM data, one cycle after address)
//   cpu_hold                          keeps the CPU in reset while RAM is owned elsewhere
//   ld_download/ld_wr/ld_index/
//   ld_addr/ld_dout                   loader session, byte strobe, image type, offset, byte
//   mem_addr/mem_d/mem_we/mem_q       external single-port RAM
//   clr_busy/ld_active                state indicators
//   ld_done                           one-cycle pulse while the final flush runs
//   ld_err                            sticky: a loader byte was dropped
//   ld_bytes                          bytes written by the current or last load (saturating)

module oric_ram_ctrl
    import oric_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLR_VALUE  = 8'hFF,
    parameter logic [7:0]        LOAD_INDEX = 8'h01,
    parameter logic [ADDR_W-1:0] LOAD_BASE  = 16'h0000
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] cpu_ad,
    input  logic [DATA_W-1:0] cpu_d,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_hold,
    input  logic              ld_download,
    input  logic              ld_wr,
    input  logic [7:0]        ld_index,
    input  logic [24:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              clr_busy,
    output logic              ld_active,
    output logic              ld_done,
    output logic              ld_err,
    output logic [16:0]       ld_bytes
);

    localparam logic [16:0] BYTES_MAX = 17'h10000;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              ld_done_q;

    logic load_req;
    logic ld_in_range;

    assign load_req    = ld_download && (ld_index == LOAD_INDEX);
    assign ld_in_range = (ld_addr[24:16] == 9'd0);

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            ld_done_q <= 1'b0;
            ld_err    <= 1'b0;
            ld_bytes  <= '0;
        end else begin
            ld_done_q <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    // clr_cnt wraps back to 0 after the last address, ready for a later restart
                    clr_cnt <= clr_cnt + 1'b1;
                    if (ld_wr) begin
                        ld_err <= 1'b1;
                    end
                    if (clr_cnt == '1) begin
                        if (load_req) begin
                            state    <= ST_LOAD;
                            ld_bytes <= '0;
                            ld_err   <= 1'b0;
                            pend_vld <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (load_req) begin
                        state    <= ST_LOAD;
                        ld_bytes <= '0;
                        ld_err   <= 1'b0;
                        pend_vld <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Each accepted byte is held for exactly one cycle on the RAM port
                    pend_vld <= 1'b0;
                    if (ld_wr) begin
                        if (ld_in_range) begin
                            pend_vld  <= 1'b1;
                            pend_addr <= LOAD_BASE + ld_addr[15:0];
                            pend_data <= ld_dout;
                            if (ld_bytes != BYTES_MAX) begin
                                ld_bytes <= ld_bytes + 1'b1;
                            end
                        end else begin
                            ld_err <= 1'b1;
                        end
                    end
                    if (!ld_download) begin
                        state     <= ST_FLUSH;
                        ld_done_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    pend_vld <= 1'b0;
                    state    <= ST_RUN;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr = clr_cnt;
        mem_d    = CLR_VALUE;
        mem_we   = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we = 1'b1;
            end
            ST_RUN: begin
                mem_addr = cpu_ad;
                mem_d    = cpu_d;
                mem_we   = cpu_cs && cpu_we;
            end
            ST_LOAD, ST_FLUSH: begin
                mem_addr = pend_addr;
                mem_d    = pend_data;
                mem_we   = pend_vld;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        // Reset is synchronous, so the register state is stale during the first
        // reset cycle; the RAM port and indicators are forced safe immediately.
        if (RESET) begin
            mem_we = 1'b0;
        end
    end

    assign cpu_q     = mem_q;
    assign cpu_hold  = RESET || (state != ST_RUN);
    assign clr_busy  = RESET || (state == ST_CLEAR);
    assign ld_active = !RESET && ((state == ST_LOAD) || (state == ST_FLUSH));
    assign ld_done   = ld_done_q && !RESET;

endmodule

// File: tb/tb_oric_ram_ctrl.sv
// tb/tb_oric_ram_ctrl.sv - self-checking bench for oric_ram_ctrl (two load bases side by side)

module tb_oric_ram_ctrl;

    localparam logic [15:0] BASE_A = 16'h0500;
    localparam logic [15:0] BASE_B = 16'hFFFF;

    logic        clk_sys;
    logic        RESET;
    logic [15:0] cpu_ad;
    logic [7:0]  cpu_d;
    logic        cpu_cs, cpu_we;
    logic        ld_download, ld_wr;
    logic [7:0]  ld_index;
    logic [24:0] ld_addr;
    logic [7:0]  ld_dout;

    logic [7:0]  a_q, b_q, a_md, b_md, a_mq, b_mq;
    logic [15:0] a_maddr, b_maddr;
    logic        a_hold, b_hold, a_mwe, b_mwe, a_clr, b_clr, a_act, b_act;
    logic        a_done, b_done, a_err, b_err;
    logic [16:0] a_bytes, b_bytes;

    oric_ram_ctrl #(.CLR_VALUE(8'hFF), .LOAD_INDEX(8'h01), .LOAD_BASE(BASE_A)) dut_a (
        .clk_sys(clk_sys), .RESET(RESET),
        .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
        .cpu_q(a_q), .cpu_hold(a_hold),
        .ld_download(ld_download), .ld_wr(ld_wr), .ld_index(ld_index),
        .ld_addr(ld_addr), .ld_dout(ld_dout),
        .mem_addr(a_maddr), .mem_d(a_md), .mem_we(a_mwe), .mem_q(a_mq),
        .clr_busy(a_clr), .ld_active(a_act), .ld_done(a_done),
        .ld_err(a_err), .ld_bytes(a_bytes)
    );

    oric_ram_ctrl #(.CLR_VALUE(8'hFF), .LOAD_INDEX(8'h01), .LOAD_BASE(BASE_B)) dut_b (
        .clk_sys(clk_sys), .RESET(RESET),
        .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
        .cpu_q(b_q), .cpu_hold(b_hold),
        .ld_download(ld_download), .ld_wr(ld_wr), .ld_index(ld_index),
        .ld_addr(ld_addr), .ld_dout(ld_dout),
        .mem_addr(b_maddr), .mem_d(b_md), .mem_we(b_mwe), .mem_q(b_mq),
        .clr_busy(b_clr), .ld_active(b_act), .ld_done(b_done),
        .ld_err(b_err), .ld_bytes(b_bytes)
    );

    // External RAMs, one-cycle read latency
    logic [7:0] ram_a [0:65535];
    logic [7:0] ram_b [0:65535];

    always @(posedge clk_sys) begin
        if (a_mwe) ram_a[a_maddr] <= a_md;
        if (b_mwe) ram_b[b_maddr] <= b_md;
        a_mq <= ram_a[a_maddr];
        b_mq <= ram_b[b_maddr];
    end

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Reference model state
    logic [7:0]  ref_a [0:65535];
    logic [7:0]  ref_b [0:65535];
    logic [23:0] qa[$], qb[$];
    logic [24:0] load_off[$];
    logic [7:0]  load_dat[$];
    logic [15:0] touched[$];
    int          exp_bytes;
    logic        exp_err;

    int checks = 0;
    int errors = 0;
    int bad_hold, bad_wr, done_a, done_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wrap_addr(input logic [15:0] base, input logic [24:0] off);
        int s;
        s = (int'(base) + int'(off)) % 65536;
        return 16'(s);
    endfunction

    // One cycle while the controller owns RAM for a load; tallies writes against the model
    task automatic step_load();
        logic [23:0] e;
        @(negedge clk_sys);
        if (!(a_hold && b_hold && a_act && b_act)) bad_hold++;
        done_a += int'(a_done);
        done_b += int'(b_done);
        if (a_mwe) begin
            if (qa.size() == 0) bad_wr++;
            else begin
                e = qa.pop_front();
                if ({a_maddr, a_md} !== e) bad_wr++;
            end
        end
        if (b_mwe) begin
            if (qb.size() == 0) bad_wr++;
            else begin
                e = qb.pop_front();
                if ({b_maddr, b_md} !== e) bad_wr++;
            end
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic run_load();
        logic [24:0] off;
        logic [7:0]  d;
        logic [15:0] aa, ab;
        bad_hold = 0; bad_wr = 0; done_a = 0; done_b = 0;
        qa.delete(); qb.delete();
        exp_bytes = 0; exp_err = 1'b0;
        ld_download = 1'b1; ld_index = 8'h01; ld_wr = 1'b0; cpu_cs = 1'b0;
        @(negedge clk_sys);
        @(posedge clk_sys);
        #1;
        // CPU activity that must be ignored during the load
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_ad = 16'($urandom); cpu_d = 8'($urandom);
        for (int i = 0; i < load_off.size(); i++) begin
            off = load_off[i];
            d   = load_dat[i];
            ld_wr = 1'b1; ld_addr = off; ld_dout = d;
            if (off < 25'h10000) begin
                aa = wrap_addr(BASE_A, off);
                ab = wrap_addr(BASE_B, off);
                qa.push_back({aa, d});
                qb.push_back({ab, d});
                ref_a[aa] = d;
                ref_b[ab] = d;
                touched.push_back(aa);
                touched.push_back(ab);
                if (exp_bytes < 65536) exp_bytes++;
            end else begin
                exp_err = 1'b1;
            end
            step_load();
            ld_wr = 1'b0;
            repeat ($urandom_range(0, 2)) step_load();
        end
        ld_download = 1'b0;
        step_load();
        step_load();
        cpu_cs = 1'b0;
        @(negedge clk_sys);
        chk("load_hold_throughout", 32'(bad_hold), 0);
        chk("load_write_seq", 32'(bad_wr), 0);
        chk("load_writes_left_a", 32'(qa.size()), 0);
        chk("load_writes_left_b", 32'(qb.size()), 0);
        chk("ld_done_pulses_a", 32'(done_a), 1);
        chk("ld_done_pulses_b", 32'(done_b), 1);
        chk("run_after_load_hold", {30'd0, a_hold, b_hold}, 0);
        chk("run_after_load_active", {30'd0, a_act, b_act}, 0);
        chk("ld_bytes_a", 32'(a_bytes), 32'(exp_bytes));
        chk("ld_bytes_b", 32'(b_bytes), 32'(exp_bytes));
        chk("ld_err_a", 32'(a_err), 32'(exp_err));
        chk("ld_err_b", 32'(b_err), 32'(exp_err));
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] ad, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_ad = ad; cpu_d = d;
        @(negedge clk_sys);
        chk("cpu_write_we", {30'd0, a_mwe, b_mwe}, 32'h3);
        chk("cpu_write_addr", 32'(a_maddr), 32'(ad));
        @(posedge clk_sys);
        #1;
        cpu_cs = 1'b0; cpu_we = 1'b0;
        ref_a[ad] = d;
        ref_b[ad] = d;
    endtask

    task automatic cpu_read(input logic [15:0] ad);
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_ad = ad;
        @(negedge clk_sys);
        @(posedge clk_sys);
        #1;
        cpu_cs = 1'b0;
        @(negedge clk_sys);
        chk("cpu_read_a", 32'(a_q), 32'(ref_a[ad]));
        chk("cpu_read_b", 32'(b_q), 32'(ref_b[ad]));
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        int bad;
        logic [15:0] ad;
        RESET = 1'b1; cpu_ad = '0; cpu_d = '0; cpu_cs = 1'b0; cpu_we = 1'b0;
        ld_download = 1'b0; ld_wr = 1'b0; ld_index = 8'h00; ld_addr = '0; ld_dout = '0;
        repeat (2) @(posedge clk_sys);
        #1;

        // Reset state
        @(negedge clk_sys);
        chk("reset_mem_we", {30'd0, a_mwe, b_mwe}, 0);
        chk("reset_cpu_hold", {30'd0, a_hold, b_hold}, 32'h3);
        chk("reset_clr_busy", {30'd0, a_clr, b_clr}, 32'h3);
        chk("reset_ld_active", {30'd0, a_act, b_act}, 0);
        chk("reset_ld_done", {30'd0, a_done, b_done}, 0);
        chk("reset_ld_err", {30'd0, a_err, b_err}, 0);
        chk("reset_ld_bytes", 32'(a_bytes) | 32'(b_bytes), 0);
        @(posedge clk_sys);
        #1;
        RESET = 1'b0;

        // Clear: one write of 0xFF per cycle at 0..FFFF, with a stray loader byte and CPU noise
        bad = 0;
        for (int i = 0; i < 65536; i++) begin
            ld_wr  = (i == 100);
            cpu_cs = ((i % 16) >= 8);
            cpu_we = 1'b1;
            cpu_ad = 16'(i * 7);
            @(negedge clk_sys);
            if (!(a_mwe && b_mwe && a_md == 8'hFF && b_md == 8'hFF &&
                  a_maddr == 16'(i) && b_maddr == 16'(i) && a_clr && a_hold)) bad++;
            @(posedge clk_sys);
            #1;
        end
        ld_wr = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
        chk("clear_sequence_bad_cycles", 32'(bad), 0);
        for (int i = 0; i < 65536; i++) begin
            ref_a[i] = 8'hFF;
            ref_b[i] = 8'hFF;
        end
        @(negedge clk_sys);
        chk("cycle65537_cpu_hold", {30'd0, a_hold, b_hold}, 0);
        chk("cycle65537_mem_we", {30'd0, a_mwe, b_mwe}, 0);
        chk("cycle65537_clr_busy", {30'd0, a_clr, b_clr}, 0);
        chk("clear_ld_wr_sets_err", {30'd0, a_err, b_err}, 32'h3);
        @(posedge clk_sys);
        #1;

        // CPU write/read
        cpu_write(16'h1234, 8'h5A);
        cpu_read(16'h1234);
        cpu_read(16'h0000);

        // Non-matching image index stays in RUN
        ld_download = 1'b1; ld_index = 8'h02;
        repeat (2) begin @(negedge clk_sys); @(posedge clk_sys); #1; end
        @(negedge clk_sys);
        chk("wrong_index_hold", {30'd0, a_hold, b_hold}, 0);
        chk("wrong_index_active", {30'd0, a_act, b_act}, 0);
        @(posedge clk_sys);
        #1;
        ld_download = 1'b0;

        // Directed: three bytes at offsets 0..2
        load_off.delete(); load_dat.delete();
        for (int i = 0; i < 3; i++) begin
            load_off.push_back(25'(i));
            load_dat.push_back(8'($urandom));
        end
        run_load();
        cpu_read(16'h0500);
        cpu_read(16'h0502);

        // Directed: wrap of base+offset, and an out-of-range offset
        load_off.delete(); load_dat.delete();
        load_off.push_back(25'h0000001); load_dat.push_back(8'hC3);
        load_off.push_back(25'h0010000); load_dat.push_back(8'h3C);
        run_load();
        cpu_read(16'h0000);
        cpu_read(16'h0501);

        // Random loads and CPU traffic
        for (int s = 0; s < 4; s++) begin
            load_off.delete(); load_dat.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
                if ($urandom_range(0, 7) == 0)
                    load_off.push_back(25'h10000 + 25'($urandom_range(0, 1000)));
                else
                    load_off.push_back(25'($urandom_range(0, 65535)));
                load_dat.push_back(8'($urandom));
            end
            run_load();
            repeat (3) cpu_write(16'($urandom), 8'($urandom));
            for (int k = 0; k < 3 && touched.size() > 0; k++) begin
                ad = touched[$urandom_range(0, touched.size() - 1)];
                cpu_read(ad);
            end
        end

        // Reset during a load after 10 bytes: clear restarts, no ld_done
        ld_download = 1'b1; ld_index = 8'h01;
        @(negedge clk_sys); @(posedge clk_sys); #1;
        for (int i = 0; i < 10; i++) begin
            ld_wr = 1'b1; ld_addr = 25'(i + 40); ld_dout = 8'(i);
            @(negedge clk_sys); @(posedge clk_sys); #1;
        end
        ld_wr = 1'b0;
        @(negedge clk_sys);
        chk("pre_reset_ld_bytes", 32'(a_bytes), 10);
        @(posedge clk_sys); #1;
        RESET = 1'b1;
        @(negedge clk_sys);
        chk("midload_reset_mem_we", {30'd0, a_mwe, b_mwe}, 0);
        chk("midload_reset_hold", {30'd0, a_hold, b_hold}, 32'h3);
        @(posedge clk_sys); #1;
        RESET = 1'b0; ld_download = 1'b0;
        bad = 0;
        done_a = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (!(a_mwe && b_mwe && a_maddr == 16'(i) && b_maddr == 16'(i) &&
                  a_md == 8'hFF && a_clr && !a_act)) bad++;
            done_a += int'(a_done) + int'(b_done);
            if (i == 0) begin
                chk("restart_ld_bytes", 32'(a_bytes) | 32'(b_bytes), 0);
            end
            @(posedge clk_sys); #1;
        end
        chk("restart_clear_seq", 32'(bad), 0);
        chk("restart_no_ld_done", 32'(done_a), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oric_ram_ctrl.md
ORIC_RAM_CTRL -- requirements
Module: oric_ram_ctrl

Interface
REQ-001 Parameter CLR_VALUE, 8'hFF, byte written to every RAM location by the clear sequence.
REQ-002 Parameter LOAD_INDEX, 8'h01, ld_index value that selects a RAM load.
REQ-003 Parameter LOAD_BASE, 16'h0000, RAM address of loader byte offset 0.
REQ-004 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 cpu_ad  in  16  CPU RAM address.
REQ-007 cpu_d  in  8  CPU write data.
REQ-008 cpu_cs, cpu_we  in  1 each  CPU RAM select and write enable.
REQ-009 cpu_q  out  8  CPU read data.
REQ-010 cpu_hold  out  1  holds the CPU in reset while high.
REQ-011 ld_download, ld_wr  in  1 each  loader session active; loader byte strobe.
REQ-012 ld_index  in  8  loader image type.
REQ-013 ld_addr  in  25  loader byte offset.
REQ-014 ld_dout  in  8  loader byte.
REQ-015 mem_addr  out  16, mem_d  out  8, mem_we  out  1  single RAM port.
REQ-016 mem_q  in  8  RAM read data, one cycle after mem_addr.
REQ-017 clr_busy, ld_active  out  1 each  state indicators.
REQ-018 ld_done  out  1  one-cycle pulse at load end.
REQ-019 ld_err  out  1  sticky load error flag.
REQ-020 ld_bytes  out  17  bytes written by the current or last load.

Function
REQ-021 FSM states: CLEAR, RUN, LOAD, FLUSH.
REQ-022 CLEAR: mem_addr=clr_cnt, mem_d=CLR_VALUE, mem_we=1; clr_cnt increments each cycle.
REQ-023 CLEAR -> RUN in the cycle after the write to address 16'hFFFF; the clear takes exactly 65536 cycles.
REQ-024 RUN: mem_addr=cpu_ad, mem_d=cpu_d, mem_we=cpu_cs&cpu_we, all combinational.
REQ-025 cpu_q = mem_q in every state; read latency is 1 cycle.
REQ-026 RUN -> LOAD when ld_download=1 and ld_index=LOAD_INDEX, sampled at a rising edge.
REQ-027 On LOAD entry: ld_bytes=0 and ld_err=0.
REQ-028 LOAD: each ld_wr registers address (LOAD_BASE+ld_addr[15:0]) mod 65536 and ld_dout; the RAM write occurs on the next cycle (mem_we=1) and ld_bytes increments.
REQ-029 In LOAD, mem_we=0 on cycles with no pending write; CPU signals are ignored.
REQ-030 ld_wr with ld_addr>=65536 is dropped: no write, ld_err=1.
REQ-031 ld_bytes saturates at 65536.
REQ-032 LOAD -> FLUSH on ld_download=0; FLUSH commits any pending write, pulses ld_done, then goes to RUN (1 cycle).
REQ-033 ld_wr arriving in CLEAR is dropped and sets ld_err; the clear is not interrupted.
REQ-034 A download still active when CLEAR ends is entered as LOAD only if ld_index matches; otherwise RUN.
REQ-035 cpu_hold=1 in CLEAR, LOAD and FLUSH; 0 in RUN.
REQ-036 clr_busy=1 only in CLEAR; ld_active=1 in LOAD and FLUSH.

Reset
REQ-037 While RESET=1: state=CLEAR, clr_cnt=0, mem_we=0, cpu_hold=1, clr_busy=1, ld_active=0, ld_done=0, ld_err=0, ld_bytes=0, pending write discarded.
REQ-038 The first clear write (address 0) occurs in the first cycle after RESET falls.
REQ-039 RESET asserted mid-clear or mid-load restarts the clear from address 0; the load is abandoned without an ld_done pulse.

Structure
REQ-040 Shared package oric_pkg holds the FSM state enum and RAM width constants (address width 16, data width 8).
REQ-041 No sub-module; the RAM array stays outside this block.

Verification
REQ-042 Release RESET -> exactly 65536 mem_we cycles with mem_d=8'hFF at addresses 0..FFFF in order; cpu_hold falls at cycle 65537.
REQ-043 RUN, CPU write 8'h5A to 16'h1234 then read it -> cpu_q=8'h5A one cycle after the read address.
REQ-044 LOAD_BASE=16'h0500, load 3 bytes at offsets 0..2 -> writes at 0500..0502, ld_bytes=3, one ld_done pulse, cpu_hold=1 throughout.
REQ-045 LOAD_BASE=16'hFFFF, offset 1 -> write at 16'h0000; offset 25'h10000 -> no write, ld_err=1.
REQ-046 RESET pulse during LOAD after 10 bytes -> clear restarts at 0, ld_bytes=0, no ld_done pulse.
REQ-047 ld_wr during CLEAR -> no extra mem_we, ld_err=1, clear still finishes at cycle 65536.
